// File: rtl/branch_resolve_unit.sv
// RV32 branch/jump condition resolver with a registered valid/ready stage and a 2-bit saturating BHT.
// Optional statistics counters are enabled by defining BRANCH_STATS_EN.
module branch_resolve_unit #(
    parameter int  XLEN      = 32,
    parameter int  BHT_DEPTH = 64,
    localparam int BHT_IDX_W = $clog2(BHT_DEPTH)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] pred_pc,
    output logic            pred_taken,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_pc,
    input  logic [XLEN-1:0] in_rs1,
    input  logic [XLEN-1:0] in_rs2,
    input  logic [3:0]      in_ctrl,
    input  logic            in_pred,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            out_taken,
    output logic            out_mispredict,
`ifdef BRANCH_STATS_EN
    output logic [31:0]     stat_resolved,
    output logic [31:0]     stat_mispredicts,
`endif
    output logic            out_illegal
);

    typedef enum logic {
        S_INIT,
        S_RUN
    } state_t;

    state_t               state;
    logic [BHT_IDX_W-1:0] init_idx;
    logic [1:0]           bht [BHT_DEPTH];

    logic                 accept;
    logic                 dec_taken;
    logic                 dec_illegal;
    logic                 dec_mispredict;
    logic                 bht_upd;
    logic [BHT_IDX_W-1:0] upd_idx;
    logic [BHT_IDX_W-1:0] look_idx;
    logic [1:0]           ctr_cur;
    logic [1:0]           ctr_next;

    assign look_idx = pred_pc[BHT_IDX_W+1:2];
    assign upd_idx  = in_pc[BHT_IDX_W+1:2];

    // Array read is combinational; same-cycle updates land on the edge, so lookup sees the old value.
    assign pred_taken = (state == S_RUN) ? bht[look_idx][1] : 1'b0;

    assign in_ready = (state == S_RUN) && !flush && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;

    always_comb begin
        dec_taken   = 1'b0;
        dec_illegal = 1'b0;
        if (in_ctrl[3]) begin
            dec_taken = 1'b1;
        end else begin
            case (in_ctrl[2:0])
                3'b000:  dec_taken = (in_rs1 == in_rs2);
                3'b001:  dec_taken = (in_rs1 != in_rs2);
                3'b100:  dec_taken = ($signed(in_rs1) < $signed(in_rs2));
                3'b101:  dec_taken = ($signed(in_rs1) >= $signed(in_rs2));
                3'b110:  dec_taken = (in_rs1 < in_rs2);
                3'b111:  dec_taken = (in_rs1 >= in_rs2);
                default: dec_illegal = 1'b1;
            endcase
        end
        dec_mispredict = (dec_taken != in_pred);
    end

    assign bht_upd = accept && !rst && !in_ctrl[3] && !dec_illegal;
    assign ctr_cur = bht[upd_idx];

    always_comb begin
        ctr_next = ctr_cur;
        if (dec_taken) begin
            if (ctr_cur != 2'b11)
                ctr_next = ctr_cur + 2'b01;
        end else begin
            if (ctr_cur != 2'b00)
                ctr_next = ctr_cur - 2'b01;
        end
    end

    always_ff @(posedge clk) begin
        if (state == S_INIT)
            bht[init_idx] <= 2'b01;
        else if (bht_upd)
            bht[upd_idx] <= ctr_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= S_INIT;
            init_idx       <= '0;
            out_valid      <= 1'b0;
            out_taken      <= 1'b0;
            out_mispredict <= 1'b0;
            out_illegal    <= 1'b0;
`ifdef BRANCH_STATS_EN
            stat_resolved    <= '0;
            stat_mispredicts <= '0;
`endif
        end else begin
            case (state)
                S_INIT: begin
                    init_idx <= init_idx + 1'b1;
                    if (init_idx == BHT_IDX_W'(BHT_DEPTH - 1))
                        state <= S_RUN;
                end
                S_RUN: begin
                    if (flush) begin
                        out_valid <= 1'b0;
                    end else if (accept) begin
                        out_valid      <= 1'b1;
                        out_taken      <= dec_taken;
                        out_mispredict <= dec_mispredict;
                        out_illegal    <= dec_illegal;
`ifdef BRANCH_STATS_EN
                        stat_resolved <= stat_resolved + 32'd1;
                        if (dec_mispredict)
                            stat_mispredicts <= stat_mispredicts + 32'd1;
`endif
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                    end
                end
                default: state <= S_INIT;
            endcase
        end
    end

    logic unused_pc_bits;
    assign unused_pc_bits = ^{pred_pc[XLEN-1:BHT_IDX_W+2], pred_pc[1:0],
                              in_pc[XLEN-1:BHT_IDX_W+2], in_pc[1:0]};

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Randomized self-checking bench for branch_resolve_unit against a behavioural reference model.
// Stats ports are checked when BRANCH_STATS_EN is defined.
module tb_branch_resolve_unit;

    localparam int XLEN  = 32;
    localparam int DEPTH = 64;

    logic            clk = 1'b0;
    logic            rst;
    logic [XLEN-1:0] pred_pc;
    logic            pred_taken;
    logic            in_valid;
    logic            in_ready;
    logic [XLEN-1:0] in_pc;
    logic [XLEN-1:0] in_rs1;
    logic [XLEN-1:0] in_rs2;
    logic [3:0]      in_ctrl;
    logic            in_pred;
    logic            flush;
    logic            out_valid;
    logic            out_ready;
    logic            out_taken;
    logic            out_mispredict;
    logic            out_illegal;
`ifdef BRANCH_STATS_EN
    logic [31:0]     stat_resolved;
    logic [31:0]     stat_mispredicts;
`endif

    always #5 clk = ~clk;

    branch_resolve_unit #(.XLEN(XLEN), .BHT_DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst            (rst),
        .pred_pc        (pred_pc),
        .pred_taken     (pred_taken),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_pc          (in_pc),
        .in_rs1         (in_rs1),
        .in_rs2         (in_rs2),
        .in_ctrl        (in_ctrl),
        .in_pred        (in_pred),
        .flush          (flush),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_taken      (out_taken),
        .out_mispredict (out_mispredict),
`ifdef BRANCH_STATS_EN
        .stat_resolved    (stat_resolved),
        .stat_mispredicts (stat_mispredicts),
`endif
        .out_illegal    (out_illegal)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: counters as plain integers 0..3, predict taken when >= 2.
    bit          m_run;
    int          m_init_left;
    bit          m_valid, m_taken, m_misp, m_ill;
    int          m_ctr [DEPTH];
    int unsigned m_res, m_mis;

    function automatic int idx_of(input logic [31:0] pc);
        return int'(pc / 4) % DEPTH;
    endfunction

    function automatic bit m_ready();
        return m_run && !flush && (!m_valid || out_ready);
    endfunction

    function automatic bit m_pred();
        return m_run && (m_ctr[idx_of(pred_pc)] >= 2);
    endfunction

    task automatic m_reset();
        m_run = 0; m_init_left = DEPTH;
        m_valid = 0; m_taken = 0; m_misp = 0; m_ill = 0;
        m_res = 0; m_mis = 0;
    endtask

    task automatic model_edge();
        bit acc, t, ill;
        int k;
        acc = in_valid && m_ready();
        if (rst) begin
            m_reset();
        end else if (!m_run) begin
            m_init_left--;
            if (m_init_left == 0) begin
                m_run = 1;
                for (int i = 0; i < DEPTH; i++) m_ctr[i] = 1;
            end
        end else if (flush) begin
            m_valid = 0;
        end else if (acc) begin
            ill = 0;
            if (in_ctrl[3]) t = 1;
            else case (in_ctrl[2:0])
                3'd0: t = (in_rs1 == in_rs2);
                3'd1: t = (in_rs1 != in_rs2);
                3'd4: t = (int'(in_rs1) < int'(in_rs2));
                3'd5: t = (int'(in_rs1) >= int'(in_rs2));
                3'd6: t = (in_rs1 < in_rs2);
                3'd7: t = (in_rs1 >= in_rs2);
                default: begin t = 0; ill = 1; end
            endcase
            m_valid = 1; m_taken = t; m_ill = ill; m_misp = (t != in_pred);
            m_res++;
            if (m_misp) m_mis++;
            if (!in_ctrl[3] && !ill) begin
                k = idx_of(in_pc);
                m_ctr[k] = t ? ((m_ctr[k] < 3) ? m_ctr[k] + 1 : 3)
                             : ((m_ctr[k] > 0) ? m_ctr[k] - 1 : 0);
            end
        end else if (out_ready) begin
            m_valid = 0;
        end
    endtask

    // One clock: settle inputs, check combinational outputs, advance, check registered outputs.
    task automatic tick();
        #1;
        check_eq("in_ready", in_ready, m_ready());
        check_eq("pred_taken", pred_taken, m_pred());
        model_edge();
        @(posedge clk);
        #1;
        check_eq("out_valid", out_valid, m_valid);
        check_eq("out_taken", out_taken, m_taken);
        check_eq("out_mispredict", out_mispredict, m_misp);
        check_eq("out_illegal", out_illegal, m_ill);
`ifdef BRANCH_STATS_EN
        check_eq("stat_resolved", stat_resolved, m_res);
        check_eq("stat_mispredicts", stat_mispredicts, m_mis);
`endif
    endtask

    task automatic wait_init();
        int cnt;
        cnt = 0;
        in_valid = 0;
        #1;
        for (int i = 0; i < 200; i++) begin
            if (in_ready) break;
            if (pred_taken !== 1'b0) check_eq("init_pred", pred_taken, 0);
            cnt++;
            tick();
        end
        check_eq("init_len", cnt, DEPTH);
    endtask

    task automatic set_op(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] pc, input logic p);
        in_valid = 1; in_ctrl = c; in_rs1 = a; in_rs2 = b; in_pc = pc; in_pred = p;
    endtask

    task automatic run_op(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] pc, input logic p);
        set_op(c, a, b, pc, p);
        tick();
        in_valid = 0;
    endtask

    initial begin
        logic held_t, held_m;
        rst = 1; in_valid = 0; flush = 0; out_ready = 1;
        in_pc = '0; in_rs1 = '0; in_rs2 = '0; in_ctrl = '0; in_pred = 0; pred_pc = '0;
        repeat (2) @(posedge clk);
        #1;
        m_reset();
        check_eq("rst_out_valid", out_valid, 0);
        check_eq("rst_out_taken", out_taken, 0);
        rst = 0;
        wait_init();
        pred_pc = 32'h0000_0abc;
        #1;
        check_eq("first_lookup", pred_taken, 0);

        // Signed vs unsigned compare on the same operands
        run_op(4'b0100, 32'hFFFF_FFFF, 32'd1, 32'h204, 1'b0);
        check_eq("blt_taken", out_taken, 1);
        check_eq("blt_misp", out_mispredict, 1);
        run_op(4'b0110, 32'hFFFF_FFFF, 32'd1, 32'h204, 1'b0);
        check_eq("bltu_taken", out_taken, 0);
        check_eq("bltu_misp", out_mispredict, 0);

        // Saturation at pc 0x100
        pred_pc = 32'h100;
        for (int i = 0; i < 3; i++) run_op(4'b0000, 32'd5, 32'd5, 32'h100, 1'b0);
        #1;
        check_eq("sat_pred_up", pred_taken, 1);
        run_op(4'b0000, 32'd5, 32'd5, 32'h100, 1'b1);
        run_op(4'b0000, 32'd5, 32'd6, 32'h100, 1'b1);
        #1;
        check_eq("sat_pred_mid", pred_taken, 1);
        run_op(4'b0000, 32'd5, 32'd6, 32'h100, 1'b1);
        #1;
        check_eq("sat_pred_down", pred_taken, 0);

        // Backpressure: held result stays stable, next op waits
        out_ready = 0;
        run_op(4'b0000, 32'd3, 32'd4, 32'h108, 1'b1);
        held_t = out_taken; held_m = out_mispredict;
        pred_pc = 32'h10c;
        for (int i = 0; i < 5; i++) begin
            set_op(4'b0001, 32'd1, 32'd2, 32'h10c, 1'b0);
            tick();
            check_eq("bp_ready", in_ready, 0);
            check_eq("bp_taken", out_taken, held_t);
            check_eq("bp_misp", out_mispredict, held_m);
        end
        out_ready = 1;
        tick();
        in_valid = 0;
        check_eq("bp_accept_valid", out_valid, 1);
        check_eq("bp_accept_taken", out_taken, 1);

        // Illegal funct3 and unconditional jump
        run_op(4'b0010, 32'd7, 32'd7, 32'h110, 1'b1);
        check_eq("ill_flag", out_illegal, 1);
        check_eq("ill_taken", out_taken, 0);
        check_eq("ill_misp", out_mispredict, 1);
        run_op(4'b1000, 32'd1, 32'd2, 32'h114, 1'b0);
        check_eq("jal_taken", out_taken, 1);
        check_eq("jal_misp", out_mispredict, 1);

        // Flush blocks acceptance
        flush = 1;
        set_op(4'b0000, 32'd9, 32'd9, 32'h118, 1'b0);
        #1;
        check_eq("flush_ready", in_ready, 0);
        tick();
        flush = 0; in_valid = 0;
        check_eq("flush_valid", out_valid, 0);

        // Reset mid-stream
        set_op(4'b0000, 32'd1, 32'd1, 32'h11c, 1'b0);
        tick();
        rst = 1;
        tick();
        rst = 0;
        check_eq("midrst_valid", out_valid, 0);
        wait_init();

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 15) == 0);
            rst       = ($urandom_range(0, 999) == 0);
            in_ctrl   = 4'($urandom);
            in_rs1    = (($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : 32'($urandom));
            in_rs2    = (($urandom_range(0, 3) == 0) ? in_rs1 : 32'($urandom));
            in_pc     = (32'($urandom) & 32'hFFFF_0000) | (32'($urandom_range(0, 15)) << 2);
            pred_pc   = (32'($urandom) & 32'hFFFF_0000) | (32'($urandom_range(0, 15)) << 2);
            in_pred   = 1'($urandom);
            tick();
        end
        rst = 0; flush = 0; in_valid = 0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
